apex_seq_ctrl: RTL

Parametrised successor to the apex7 watch/sequencer controller, scaled to a configurable counter width and channel count. It contains four pieces of state: a gated watch counter, a four-state start sequencer, a bank of per-channel sticky capture flags selected by an index/mask decode, and a sticky error flag set at a programmable counter value. It sits behind the command decoder and drives the channel status bus and the error/end indicators.

---
 rtl/apex_seq_pkg.sv | 18 +
 rtl/apex_wcnt.sv | 36 +++
 rtl/apex_seq_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/apex_seq_pkg.sv
// Shared types and sizing helpers for the apex watch/sequencer controller.
package apex_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } seq_state_e;

    localparam int APEX_NCH_MIN = 2;
    localparam int APEX_NCH_MAX = 16;

    function automatic int idx_w(input int nch);
        return (nch < APEX_NCH_MIN) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/apex_wcnt.sv
// Gated watch counter with synchronous clear; wrap flags the all-ones step.
module apex_wcnt #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sclr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sclr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = en & (&cnt_q);

endmodule

// File: rtl/apex_seq_ctrl.sv
// Watch/sequencer controller: start sequencer FSM, capture-ready decode,
// sticky per-channel capture flags and a sticky error flag.
module apex_seq_ctrl
    import apex_seq_pkg::*;
#(
    parameter int CNT_W   = 7,
    parameter int NCH     = 6,
    parameter int IDX_W   = idx_w(NCH),
    parameter int ERR_VAL = 82
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             owl_n,
    input  logic             clr,
    input  logic             watch,
    input  logic             fbi,
    input  logic             orwd_n,
    input  logic [IDX_W-1:0] ibt,
    input  logic             ibt_vld,
    input  logic [NCH-1:0]   cat,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       state,
    output logic [NCH-1:0]   pluto,
    output logic             orwd_f,
    output logic             verr_f,
    output logic             end_p
);

    localparam logic [IDX_W:0]   NCH_L = (IDX_W + 1)'(NCH);
    localparam logic [CNT_W-1:0] ERR_L = CNT_W'(ERR_VAL);

    seq_state_e       state_q, state_d;
    logic [NCH-1:0]   pluto_q, pluto_d;
    logic             verr_q, verr_d;
    logic             end_p_q, end_p_d;
    logic             cap_rdy;
    logic             sclr;
    logic             cnt_en;
    logic             wrap;

    // cat is only indexed once ibt is known to be a real channel.
    always_comb begin
        cap_rdy = 1'b0;
        if (watch && ibt_vld && ({1'b0, ibt} < NCH_L)) begin
            cap_rdy = ~cat[ibt];
        end
    end

    assign orwd_f = ~cap_rdy;
    assign sclr   = ~owl_n | clr;
    assign cnt_en = watch & (state_q != IDLE);

    apex_wcnt #(
        .CNT_W (CNT_W)
    ) u_wcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .sclr  (sclr),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // clr freezes the sequencer; only owl_n low drops it back to IDLE.
    always_comb begin
        state_d = state_q;
        end_p_d = 1'b0;
        if (!owl_n) begin
            state_d = IDLE;
        end else if (!clr) begin
            case (state_q)
                IDLE: if (fbi && watch) state_d = ARM;
                ARM: begin
                    if (!fbi)          state_d = IDLE;
                    else if (!orwd_f)  state_d = RUN;
                end
                RUN: begin
                    if (wrap) begin
                        state_d = IDLE;
                        end_p_d = 1'b1;
                    end else if (!orwd_n) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!fbi)          state_d = IDLE;
                    else if (orwd_n)   state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pluto_d = pluto_q;
        verr_d  = verr_q;
        if (sclr) begin
            pluto_d = '0;
            verr_d  = 1'b0;
        end else begin
            if (state_q == RUN && !orwd_f) begin
                pluto_d[ibt] = 1'b1;
            end
            if ((state_q == RUN || state_q == HOLD) && watch && cnt == ERR_L) begin
                verr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pluto_q <= '0;
            verr_q  <= 1'b0;
            end_p_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pluto_q <= pluto_d;
            verr_q  <= verr_d;
            end_p_q <= end_p_d;
        end
    end

    assign state  = state_q;
    assign pluto  = pluto_q;
    assign verr_f = verr_q;
    assign end_p  = end_p_q;

endmodule
